// File: rtl/board_redraw_sequencer.sv
// Cell-redraw initiator: walks the board row-major, fetches each digit and runs the
// one-cycle SIGNAL / multi-cycle DRAW handshake with the cell drawer for every cell.
// Optional feature macro: BOARD_REDRAW_DIRTY_ONLY_EN (redraw only cells marked dirty).

module board_redraw_sequencer #(
    parameter  int BOARD_DIM = 9,
    localparam int CELLS     = BOARD_DIM * BOARD_DIM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [6:0] board_rd_addr,
    input  logic [3:0] board_rd_data,
    output logic [3:0] cell_row,
    output logic [3:0] cell_col,
    output logic [3:0] cell_data,
    output logic       req_signal,
    output logic       req_draw,
    input  logic       drawing_cell,
    input  logic       dirty_set,
    input  logic [6:0] dirty_addr
);

    localparam logic [6:0] LAST_IDX = 7'(CELLS - 1);
    localparam logic [3:0] LAST_COL = 4'(BOARD_DIM - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SIGNAL = 3'd2,
        ST_DRAW   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic [6:0] idx_r;
    logic [6:0] idx_s;
    logic [3:0] row_r;
    logic [3:0] row_s;
    logic [3:0] col_r;
    logic [3:0] col_s;
    logic       advance_s;
    logic       clear_pos_s;
    logic       first_draw_r;
    logic       cell_dirty_s;

    logic       busy_r;
    logic       done_r;
    logic       req_signal_r;
    logic       req_draw_r;
    logic [3:0] cell_row_r;
    logic [3:0] cell_col_r;
    logic [3:0] cell_data_r;

`ifdef BOARD_REDRAW_DIRTY_ONLY_EN
    logic [CELLS-1:0] dirty_r;
    logic [CELLS-1:0] dirty_s;

    // Dirty bitmap next value: a set request beats the clear of the cell leaving SIGNAL
    always_comb begin
        dirty_s = dirty_r;
        for (int i = 0; i < CELLS; i++) begin
            if (dirty_set && (dirty_addr == 7'(i))) begin
                dirty_s[i] = 1'b1;
            end else if ((state_r == ST_SIGNAL) && (idx_r == 7'(i))) begin
                dirty_s[i] = 1'b0;
            end else begin
                dirty_s[i] = dirty_r[i];
            end
        end
    end

    // Dirty bitmap register; all ones after reset so the first pass is a full redraw
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirty_r <= '1;
        end else begin
            dirty_r <= dirty_s;
        end
    end

    assign cell_dirty_s = dirty_r[idx_r];
`else
    logic unused_dirty_s;
    assign unused_dirty_s = ^{dirty_set, dirty_addr};
    assign cell_dirty_s   = 1'b1;
`endif

    // Next-state logic and position-advance decisions
    always_comb begin
        next_state_s = state_r;
        advance_s    = 1'b0;
        clear_pos_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clear_pos_s = 1'b1;
                if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // A clean cell costs this one FETCH cycle and is never signalled
                if (cell_dirty_s) begin
                    next_state_s = ST_SIGNAL;
                end else if (idx_r == LAST_IDX) begin
                    next_state_s = ST_DONE;
                end else begin
                    advance_s    = 1'b1;
                    next_state_s = ST_FETCH;
                end
            end
            ST_SIGNAL: begin
                next_state_s = ST_DRAW;
            end
            ST_DRAW: begin
                // The drawer flag is only meaningful from the second DRAW cycle on
                if (first_draw_r || drawing_cell) begin
                    next_state_s = ST_DRAW;
                end else if (idx_r == LAST_IDX) begin
                    next_state_s = ST_DONE;
                end else begin
                    advance_s    = 1'b1;
                    next_state_s = ST_FETCH;
                end
            end
            ST_DONE: begin
                clear_pos_s  = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                clear_pos_s  = 1'b1;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Index, row and column counters; the index saturates at the last cell
    always_comb begin
        idx_s = idx_r;
        row_s = row_r;
        col_s = col_r;
        if (clear_pos_s) begin
            idx_s = 7'd0;
            row_s = 4'd0;
            col_s = 4'd0;
        end else if (advance_s && (idx_r < LAST_IDX)) begin
            idx_s = idx_r + 7'd1;
            if (col_r == LAST_COL) begin
                col_s = 4'd0;
                row_s = row_r + 4'd1;
            end else begin
                col_s = col_r + 4'd1;
                row_s = row_r;
            end
        end else begin
            idx_s = idx_r;
        end
    end

    // State, position and handshake output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 7'd0;
            row_r        <= 4'd0;
            col_r        <= 4'd0;
            first_draw_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            req_signal_r <= 1'b0;
            req_draw_r   <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            idx_r        <= idx_s;
            row_r        <= row_s;
            col_r        <= col_s;
            first_draw_r <= (state_r == ST_SIGNAL);
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= (next_state_s == ST_DONE);
            req_signal_r <= (next_state_s == ST_SIGNAL);
            req_draw_r   <= (next_state_s == ST_DRAW);
        end
    end

    // Cell descriptor captured only on the FETCH to SIGNAL edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_row_r  <= 4'd0;
            cell_col_r  <= 4'd0;
            cell_data_r <= 4'd0;
        end else if ((state_r == ST_FETCH) && (next_state_s == ST_SIGNAL)) begin
            cell_row_r  <= row_r;
            cell_col_r  <= col_r;
            cell_data_r <= board_rd_data;
        end else begin
            cell_row_r  <= cell_row_r;
            cell_col_r  <= cell_col_r;
            cell_data_r <= cell_data_r;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign board_rd_addr = idx_r;
    assign cell_row      = cell_row_r;
    assign cell_col      = cell_col_r;
    assign cell_data     = cell_data_r;
    assign req_signal    = req_signal_r;
    assign req_draw      = req_draw_r;

endmodule

// File: tb/tb_board_redraw_sequencer.sv
// Scoreboard bench for board_redraw_sequencer: drawer model, combinational board storage
// holding index % 10, and a queue of expected SIGNAL cells per pass.

module tb_board_redraw_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [6:0] board_rd_addr;
    logic [3:0] board_rd_data;
    logic [3:0] cell_row;
    logic [3:0] cell_col;
    logic [3:0] cell_data;
    logic       req_signal;
    logic       req_draw;
    logic       drawing_cell;
    logic       dirty_set;
    logic [6:0] dirty_addr;

    typedef struct packed {
        logic [6:0] idx;
        logic [3:0] row;
        logic [3:0] col;
        logic [3:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [80:0] exp_dirty;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          drawer_len   = 4;
    int          dcnt         = 0;
    bit          found;
    bit          hit3;

    board_redraw_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .board_rd_addr(board_rd_addr),
        .board_rd_data(board_rd_data),
        .cell_row     (cell_row),
        .cell_col     (cell_col),
        .cell_data    (cell_data),
        .req_signal   (req_signal),
        .req_draw     (req_draw),
        .drawing_cell (drawing_cell),
        .dirty_set    (dirty_set),
        .dirty_addr   (dirty_addr)
    );

    always #5 clk = ~clk;

    assign board_rd_data = 4'(board_rd_addr % 7'd10);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drawer model: raises its flag on the edge ending SIGNAL, holds it drawer_len cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            drawing_cell <= 1'b0;
            dcnt         <= 0;
        end else if (req_signal) begin
            drawing_cell <= 1'b1;
            dcnt         <= drawer_len;
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
        end else if (dcnt == 1) begin
            dcnt         <= 0;
            drawing_cell <= 1'b0;
        end
    end

    // Scoreboard: every SIGNAL cycle must match the next expected cell
    always @(negedge clk) begin
        if (!rst && req_signal) begin
            check_eq("sig_draw_exclusive", req_draw, 1'b0);
            if (sb_q.size() == 0) begin
                check_eq("sig_unexpected", req_signal, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("sig_addr", board_rd_addr, mon_e.idx);
                check_eq("sig_row",  cell_row,      mon_e.row);
                check_eq("sig_col",  cell_col,      mon_e.col);
                check_eq("sig_data", cell_data,     mon_e.data);
            end
        end
    end

    task automatic push_expected();
        for (int i = 0; i < 81; i++) begin
            if (exp_dirty[i]) begin
                exp_t e;
                e.idx  = 7'(i);
                e.row  = 4'(i / 9);
                e.col  = 4'(i % 9);
                e.data = 4'(i % 10);
                sb_q.push_back(e);
            end
        end
    endtask

    function automatic int exp_done_cycle(input int len);
        int c = 0;
        for (int i = 0; i < 81; i++) begin
            c += exp_dirty[i] ? (len + 3) : 1;
        end
        return c + 1;
    endfunction

    task automatic model_pass_done();
`ifdef BOARD_REDRAW_DIRTY_ONLY_EN
        exp_dirty = '0;
`endif
    endtask

    task automatic set_dirty(input logic [6:0] a);
        @(negedge clk);
        dirty_set  = 1'b1;
        dirty_addr = a;
        @(negedge clk);
        dirty_set  = 1'b0;
`ifdef BOARD_REDRAW_DIRTY_ONLY_EN
        if (a < 7'd81) exp_dirty[a] = 1'b1;
`endif
    endtask

    task automatic run_pass(input int len, input bit hold_start);
        int k;
        int exp_k;
        drawer_len = len;
        push_expected();
        exp_k = exp_done_cycle(len);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        k = 1;
        while (!done && k < exp_k + 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("done_seen", done, 1'b1);
        check_eq("done_cycle", k, exp_k);
        check_eq("done_busy", busy, 1'b1);
        check_eq("sb_drained", sb_q.size(), 0);
        @(negedge clk);
        check_eq("done_width", done, 1'b0);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_addr", board_rd_addr, 7'd0);
        start = 1'b0;
        sb_q.delete();
        model_pass_done();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        dirty_set  = 1'b0;
        dirty_addr = 7'd0;
        exp_dirty  = '1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",       busy,          1'b0);
        check_eq("rst_done",       done,          1'b0);
        check_eq("rst_req_signal", req_signal,    1'b0);
        check_eq("rst_req_draw",   req_draw,      1'b0);
        check_eq("rst_addr",       board_rd_addr, 7'd0);
        check_eq("rst_row",        cell_row,      4'd0);
        check_eq("rst_col",        cell_col,      4'd0);
        check_eq("rst_data",       cell_data,     4'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_no_start", busy, 1'b0);

        run_pass(5, 1'b0);
        run_pass(1, 1'b1);

        // Reset in the middle of cell 40's DRAW phase
        drawer_len = 3;
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (req_draw && board_rd_addr == 7'd40) found = 1'b1;
        end
        check_eq("reach_cell40", found, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midrst_req_draw",   req_draw,      1'b0);
        check_eq("midrst_req_signal", req_signal,    1'b0);
        check_eq("midrst_busy",       busy,          1'b0);
        check_eq("midrst_addr",       board_rd_addr, 7'd0);
        check_eq("midrst_row",        cell_row,      4'd0);
        sb_q.delete();
        exp_dirty = '1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_pass(4, 1'b0);

        // Selective redraw; out-of-range address must be ignored
        set_dirty(7'd5);
        set_dirty(7'd80);
        set_dirty(7'd100);
        run_pass(2, 1'b0);

        // Set cell 3 dirty again during its own SIGNAL cycle
        set_dirty(7'd3);
        hit3 = 1'b0;
        fork
            run_pass(2, 1'b0);
            begin
                for (int n = 0; n < 1000 && !hit3; n++) begin
                    @(negedge clk);
                    if (req_signal && board_rd_addr == 7'd3) hit3 = 1'b1;
                end
                if (hit3) begin
                    dirty_set  = 1'b1;
                    dirty_addr = 7'd3;
                    @(negedge clk);
                    dirty_set  = 1'b0;
                end
            end
        join
        check_eq("hit_cell3", hit3, 1'b1);
`ifdef BOARD_REDRAW_DIRTY_ONLY_EN
        exp_dirty[3] = 1'b1;
`endif
        run_pass(3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/board_redraw_sequencer.md
# board_redraw_sequencer

Initiator side of the cell-draw handshake. On a redraw request it walks the 9×9 Sudoku board in row-major order, reads each cell digit from board storage, and drives the per-cell drawer through a one-cycle signal phase and a draw phase. For each cell it waits for the drawer's busy flag to drop before moving to the next cell. It sits between the top-level screen FSM and the cell drawer, and produces the `cell_signal` and `cell_draw` phases that the top level maps onto `sys_state`.

## Interface
Parameters:
- `BOARD_DIM`, default 9: cells per row and per column.
- `CELLS`, default 81: `BOARD_DIM*BOARD_DIM`, derived, not overridden.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: redraw request, sampled in IDLE only.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse at the end of a pass.
- `board_rd_addr` output 7: cell index 0..80, `row*9+col`.
- `board_rd_data` input 4: digit at `board_rd_addr`, valid one cycle after the address is presented.
- `cell_row` output 4: row 0..8 of the current cell, registered.
- `cell_col` output 4: column 0..8 of the current cell, registered.
- `cell_data` output 4: captured digit, registered.
- `req_signal` output 1: high during the SIGNAL phase; the top level maps it to `cell_signal`.
- `req_draw` output 1: high during the DRAW phase; the top level maps it to `cell_draw`.
- `drawing_cell` input 1: drawer busy flag, raised by the drawer on the edge that ends SIGNAL.
- `dirty_set` input 1: mark a cell dirty. Used only with `DIRTY_ONLY_EN`.
- `dirty_addr` input 7: index for `dirty_set`.

## Operation
- States: IDLE, FETCH, SIGNAL, DRAW, DONE.
- IDLE: index = 0. If `start`=1, go to FETCH.
- FETCH: `board_rd_addr` = index. Next state is SIGNAL.
- SIGNAL: `cell_data` is captured from `board_rd_data` on entry. `cell_row` and `cell_col` are captured from the index. `req_signal` = 1 for exactly one cycle. Next state is DRAW.
- DRAW: `req_draw` = 1. The drawer flag is not evaluated on the first DRAW cycle; the drawer raises it on the SIGNAL→DRAW edge.
  - While `drawing_cell` = 1, stay in DRAW.
  - When `drawing_cell` = 0 and index < 80: increment the index, update row and col (col wraps 8→0 and row increments), go to FETCH.
  - When `drawing_cell` = 0 and index = 80: go to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Row and column are kept as separate counters, not divided from the index. The index is 7 bits and saturates at 80; it never wraps past 80.
- `start` outside IDLE is ignored; there is no queueing.
- `req_signal` and `req_draw` are never high together.
- Reset values:
  - state = IDLE, index, row and col = 0.
  - `cell_row`, `cell_col`, `cell_data`, `board_rd_addr` = 0.
  - `req_signal`, `req_draw`, `busy`, `done` = 0.
  - Dirty bitmap = all ones, so a full redraw follows reset.
- Reset asserted mid-pass: all outputs return to their reset values immediately. The drawer then sees neither request and drops `drawing_cell` on its own.

## Timing
- `start` sampled high in IDLE: FETCH is entered on the next edge.
- Per cell: FETCH 1 cycle + SIGNAL 1 cycle + DRAW (drawer busy length + 1) cycles.
- With the 40×40-pixel drawer, the flag is high for 1600 cycles. That gives DRAW = 1601 cycles and 1603 cycles per cell.
- Full pass: 81×1603 = 129843 cycles from FETCH entry to DONE entry. `done` is high in cycle 129844.
- `board_rd_addr` is stable from FETCH through the end of DRAW.
- `cell_*` outputs change only on the FETCH→SIGNAL edge.

## Configuration
- `BOARD_REDRAW_DIRTY_ONLY_EN` defined: the block keeps an 81-bit dirty bitmap.
  - `dirty_set` sets `bit[dirty_addr]`. An address above 80 is ignored.
  - In FETCH, a clean cell is skipped. The index advances (or the block goes to DONE at index 80) without entering SIGNAL, costing 1 cycle per skipped cell.
  - A drawn cell's bit is cleared on the SIGNAL edge.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Macro undefined: there is no bitmap; every pass draws all 81 cells, and `dirty_set`/`dirty_addr` are ignored.

## Test plan
- Full pass with a drawer model that stays busy for 1600 cycles, `start` pulsed: 81 SIGNAL pulses in order (0,0),(0,1)…(8,8); `done` exactly 129844 cycles after the `start` edge.
- Board storage holds `digit = index % 10`: at each SIGNAL, `cell_data` equals that value, and `cell_col` wraps 8→0 with `cell_row` incrementing.
- `start` held high throughout a pass: no restart and no second pass until IDLE is seen; exactly one `done` pulse per pass.
- Reset asserted at cell 40 mid-DRAW: `req_draw`, `busy` and `board_rd_addr` go to 0 within the same cycle; a new `start` redraws from (0,0).
- With `BOARD_REDRAW_DIRTY_ONLY_EN`, after one full pass set cells 5 and 80, then `start`: exactly two SIGNAL pulses at (0,5) and (8,8); `done` at 81 − 2 + 2×1603 + 1 cycles.
- With `BOARD_REDRAW_DIRTY_ONLY_EN`, `dirty_set` for cell 3 in its own SIGNAL cycle: the bit stays set and cell 3 is redrawn on the next pass.
